// File: rtl/t5_pkg.sv
// Shared constants for the t5 integer pipeline: load funct3 codes,
// byte-lane selects and the load-stage FSM encoding.
package t5_pkg;

  // funct3 encodings of the load instructions
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // byte-lane selects, shared with the request stage
  localparam logic [3:0] SEL_B0 = 4'b0001;
  localparam logic [3:0] SEL_B1 = 4'b0010;
  localparam logic [3:0] SEL_B2 = 4'b0100;
  localparam logic [3:0] SEL_B3 = 4'b1000;
  localparam logic [3:0] SEL_H0 = 4'b0011;
  localparam logic [3:0] SEL_H2 = 4'b1100;
  localparam logic [3:0] SEL_W0 = 4'b1111;

  // access FSM
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } t5_state_e;

endpackage

// File: rtl/t5_load_align.sv
// Load data alignment: picks the addressed lanes out of the bus word and
// sign/zero extends them according to funct3. Flags any lane/size
// combination that a load cannot legally produce.
module t5_load_align
  import t5_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_dti,
  input  logic [3:0]      i_sel,
  input  logic [2:0]      i_fn3,
  output logic [XLEN-1:0] o_data,
  output logic            o_illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_isb;
  logic        w_ish;
  logic        w_isw;

  // lane extraction and access-size classification from the lane select
  always_comb begin
    w_byte = '0;
    w_half = '0;
    w_isb  = 1'b0;
    w_ish  = 1'b0;
    w_isw  = 1'b0;
    case (i_sel)
      SEL_B0: begin w_byte = i_dti[7:0];   w_isb = 1'b1; end
      SEL_B1: begin w_byte = i_dti[15:8];  w_isb = 1'b1; end
      SEL_B2: begin w_byte = i_dti[23:16]; w_isb = 1'b1; end
      SEL_B3: begin w_byte = i_dti[31:24]; w_isb = 1'b1; end
      SEL_H0: begin w_half = i_dti[15:0];  w_ish = 1'b1; end
      SEL_H2: begin w_half = i_dti[31:16]; w_ish = 1'b1; end
      SEL_W0: w_isw = 1'b1;
      default: ;
    endcase
  end

  // extension by funct3; a size that disagrees with the lane select is illegal
  always_comb begin
    o_data    = '0;
    o_illegal = 1'b1;
    case (i_fn3)
      F3_LB:  if (w_isb) begin o_data = {{(XLEN-8){w_byte[7]}}, w_byte};   o_illegal = 1'b0; end
      F3_LBU: if (w_isb) begin o_data = {{(XLEN-8){1'b0}}, w_byte};        o_illegal = 1'b0; end
      F3_LH:  if (w_ish) begin o_data = {{(XLEN-16){w_half[15]}}, w_half}; o_illegal = 1'b0; end
      F3_LHU: if (w_ish) begin o_data = {{(XLEN-16){1'b0}}, w_half};       o_illegal = 1'b0; end
      F3_LW:  if (w_isw) begin o_data = i_dti;                             o_illegal = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/t5_load.sv
// t5 memory-return / writeback stage. Waits for the data-bus ack (bounded
// by TMO cycles), aligns load data and registers the register-file write
// port. Non-memory results pass through the same output register.
module t5_load
  import t5_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TMO  = 255
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            sena,
  input  logic [XLEN-1:0] dwb_dti,
  input  logic            dwb_ack,
  input  logic            xstb,
  input  logic            xwre,
  input  logic [3:0]      xsel,
  input  logic [2:0]      xfn3,
  input  logic [4:0]      xrd,
  input  logic            xwen,
  input  logic [XLEN-1:0] xalu,
  output logic            mstall,
  output logic [XLEN-1:0] mdat,
  output logic [4:0]      mrd,
  output logic            mwre,
  output logic            merr
);

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  t5_state_e       r_state;
  t5_state_e       w_state_nxt;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_nxt;
  logic            w_ack;
  logic            w_stall;
  logic            w_done;
  logic            w_abort;
  logic            w_adv;
  logic [XLEN-1:0] w_ldat;
  logic            w_illegal;
  logic [XLEN-1:0] r_mdat;
  logic [4:0]      r_mrd;
  logic            r_mwre;
  logic            r_merr;

  // an ack arriving during reset must not complete anything
  assign w_ack = dwb_ack & ~srst;
  assign w_adv = sena & ~w_stall;

  t5_load_align #(.XLEN(XLEN)) u_align (
    .i_dti     (dwb_dti),
    .i_sel     (xsel),
    .i_fn3     (xfn3),
    .o_data    (w_ldat),
    .o_illegal (w_illegal)
  );

  // state and wait-counter register
  always_ff @(posedge sclk) begin
    if (srst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // next state: enter WAIT on an unacked access, leave on ack, timeout or dropped strobe
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (xstb && !w_ack) w_state_nxt = WAIT;
      end
      WAIT: begin
        w_cnt_nxt = r_cnt + 8'd1;
        if (!xstb || w_ack || (r_cnt == TMO_LAST)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // stall / completion / abort decode; ack takes priority over the timeout
  always_comb begin
    w_stall = 1'b0;
    w_done  = 1'b0;
    w_abort = 1'b0;
    if (xstb && !srst) begin
      case (r_state)
        IDLE: begin
          if (w_ack) w_done  = 1'b1;
          else       w_stall = 1'b1;
        end
        WAIT: begin
          if (w_ack)                    w_done  = 1'b1;
          else if (r_cnt == TMO_LAST)   w_abort = 1'b1;
          else                          w_stall = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // writeback register: loads on advance, otherwise inserts a bubble
  always_ff @(posedge sclk) begin
    if (srst) begin
      r_mdat <= '0;
      r_mrd  <= '0;
      r_mwre <= 1'b0;
      r_merr <= 1'b0;
    end else if (!w_adv) begin
      r_mwre <= 1'b0;
      r_merr <= 1'b0;
    end else if (!xstb) begin
      r_mdat <= xalu;
      r_mrd  <= xrd;
      r_mwre <= xwen;
      r_merr <= 1'b0;
    end else if (w_abort) begin
      r_mrd  <= xrd;
      r_mwre <= 1'b0;
      r_merr <= 1'b1;
    end else if (xwre) begin
      r_mrd  <= xrd;
      r_mwre <= 1'b0;
      r_merr <= 1'b0;
    end else if (w_done && w_illegal) begin
      r_mrd  <= xrd;
      r_mwre <= 1'b0;
      r_merr <= 1'b1;
    end else begin
      r_mdat <= w_ldat;
      r_mrd  <= xrd;
      r_mwre <= xwen;
      r_merr <= 1'b0;
    end
  end

  assign mstall = w_stall;
  assign mdat   = r_mdat;
  assign mrd    = r_mrd;
  assign mwre   = r_mwre;
  assign merr   = r_merr;

endmodule

// File: tb/tb_t5_load.sv
// Directed bench for t5_load (TMO=4): loads, stores, ALU pass-through,
// timeout, illegal lanes and reset during a pending access.
module tb_t5_load;
  import t5_pkg::*;

  logic        sclk = 1'b0;
  logic        srst, sena, dwb_ack, xstb, xwre, xwen;
  logic [31:0] dwb_dti, xalu;
  logic [3:0]  xsel;
  logic [2:0]  xfn3;
  logic [4:0]  xrd;
  logic        mstall, mwre, merr;
  logic [31:0] mdat;
  logic [4:0]  mrd;

  int checks   = 0;
  int failures = 0;

  t5_load #(.XLEN(32), .TMO(4)) dut (
    .sclk(sclk), .srst(srst), .sena(sena), .dwb_dti(dwb_dti), .dwb_ack(dwb_ack),
    .xstb(xstb), .xwre(xwre), .xsel(xsel), .xfn3(xfn3), .xrd(xrd), .xwen(xwen),
    .xalu(xalu), .mstall(mstall), .mdat(mdat), .mrd(mrd), .mwre(mwre), .merr(merr)
  );

  always #5 sclk = ~sclk;

  // quiet inputs: pipeline held, no access
  task automatic idle_inputs();
    srst = 1'b0; sena = 1'b0; dwb_ack = 1'b0; dwb_dti = '0; xstb = 1'b0;
    xwre = 1'b0; xsel = '0; xfn3 = '0; xrd = '0; xwen = 1'b0; xalu = '0;
  endtask

  task automatic test_reset();
    @(negedge sclk);
    idle_inputs();
    srst = 1'b1; xstb = 1'b1; dwb_ack = 1'b1;
    @(posedge sclk); @(negedge sclk);
    checks++; if (mdat !== 32'h0) begin failures++; $display("FAIL reset_mdat got=%h exp=%h", mdat, 32'h0); end
    checks++; if (mrd !== 5'd0) begin failures++; $display("FAIL reset_mrd got=%0d exp=0", mrd); end
    checks++; if (mwre !== 1'b0) begin failures++; $display("FAIL reset_mwre got=%b exp=0", mwre); end
    checks++; if (merr !== 1'b0) begin failures++; $display("FAIL reset_merr got=%b exp=0", merr); end
    idle_inputs();
    #1;
    checks++; if (mstall !== 1'b0) begin failures++; $display("FAIL reset_mstall got=%b exp=0", mstall); end
  endtask

  task automatic test_lb();
    @(negedge sclk);
    idle_inputs();
    sena = 1; xstb = 1; xsel = SEL_B2; xfn3 = F3_LB; dwb_dti = 32'h12803456; dwb_ack = 1; xrd = 5'd5; xwen = 1;
    #1;
    checks++; if (mstall !== 1'b0) begin failures++; $display("FAIL lb_mstall got=%b exp=0", mstall); end
    @(posedge sclk); #1;
    checks++; if (mdat !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_mdat got=%h exp=%h", mdat, 32'hFFFFFF80); end
    checks++; if (mrd !== 5'd5) begin failures++; $display("FAIL lb_mrd got=%0d exp=5", mrd); end
    checks++; if (mwre !== 1'b1) begin failures++; $display("FAIL lb_mwre got=%b exp=1", mwre); end
  endtask

  task automatic test_lhu();
    int stalls = 0;
    @(negedge sclk);
    idle_inputs();
    sena = 1; xstb = 1; xsel = SEL_H2; xfn3 = F3_LHU; dwb_dti = 32'hBEEF0000; xrd = 5'd7; xwen = 1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge sclk);
      dwb_ack = (i == 3);
      #1;
      if (mstall === 1'b1) stalls++;
      checks++; if (mstall !== (i < 3)) begin failures++; $display("FAIL lhu_mstall cyc=%0d got=%b exp=%b", i, mstall, (i < 3)); end
      @(posedge sclk); #1;
      if (i < 3) begin
        checks++; if (mwre !== 1'b0) begin failures++; $display("FAIL lhu_bubble cyc=%0d mwre got=%b exp=0", i, mwre); end
      end
    end
    checks++; if (stalls != 3) begin failures++; $display("FAIL lhu_stall_len got=%0d exp=3", stalls); end
    checks++; if (mdat !== 32'h0000BEEF) begin failures++; $display("FAIL lhu_mdat got=%h exp=%h", mdat, 32'h0000BEEF); end
    checks++; if (mwre !== 1'b1) begin failures++; $display("FAIL lhu_mwre got=%b exp=1", mwre); end
    checks++; if (mrd !== 5'd7) begin failures++; $display("FAIL lhu_mrd got=%0d exp=7", mrd); end
  endtask

  task automatic test_store();
    @(negedge sclk);
    idle_inputs();
    sena = 1; xstb = 1; xwre = 1; xsel = SEL_W0; xfn3 = F3_LW; xrd = 5'd9; xwen = 1;
    #1;
    checks++; if (mstall !== 1'b1) begin failures++; $display("FAIL sw_mstall0 got=%b exp=1", mstall); end
    @(negedge sclk);
    dwb_ack = 1;
    #1;
    checks++; if (mstall !== 1'b0) begin failures++; $display("FAIL sw_mstall1 got=%b exp=0", mstall); end
    @(posedge sclk); #1;
    checks++; if (mwre !== 1'b0) begin failures++; $display("FAIL sw_mwre got=%b exp=0", mwre); end
    checks++; if (merr !== 1'b0) begin failures++; $display("FAIL sw_merr got=%b exp=0", merr); end
    checks++; if (mdat !== 32'h0000BEEF) begin failures++; $display("FAIL sw_mdat_hold got=%h exp=%h", mdat, 32'h0000BEEF); end
  endtask

  task automatic test_timeout();
    @(negedge sclk);
    idle_inputs();
    sena = 1; xstb = 1; xsel = SEL_W0; xfn3 = F3_LW; dwb_dti = 32'hA5A5A5A5; xrd = 5'd3; xwen = 1;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge sclk);
      #1;
      checks++; if (mstall !== (i < 4)) begin failures++; $display("FAIL tmo_mstall cyc=%0d got=%b exp=%b", i, mstall, (i < 4)); end
      @(posedge sclk); #1;
      if (i < 4) begin
        checks++; if (merr !== 1'b0) begin failures++; $display("FAIL tmo_early_merr cyc=%0d got=%b exp=0", i, merr); end
      end
    end
    checks++; if (merr !== 1'b1) begin failures++; $display("FAIL tmo_merr got=%b exp=1", merr); end
    checks++; if (mwre !== 1'b0) begin failures++; $display("FAIL tmo_mwre got=%b exp=0", mwre); end
    checks++; if (mdat !== 32'h0000BEEF) begin failures++; $display("FAIL tmo_mdat_hold got=%h exp=%h", mdat, 32'h0000BEEF); end
    checks++; if (dut.r_state !== IDLE) begin failures++; $display("FAIL tmo_state got=%0d exp=%0d", dut.r_state, IDLE); end
    @(negedge sclk);
    idle_inputs();
    @(posedge sclk); #1;
    checks++; if (merr !== 1'b0) begin failures++; $display("FAIL tmo_merr_pulse got=%b exp=0", merr); end
  endtask

  task automatic test_ack_at_timeout();
    @(negedge sclk);
    idle_inputs();
    sena = 1; xstb = 1; xsel = SEL_B0; xfn3 = F3_LBU; dwb_dti = 32'h000000F0; xrd = 5'd11; xwen = 1;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge sclk);
      dwb_ack = (i == 4);
      #1;
      checks++; if (mstall !== (i < 4)) begin failures++; $display("FAIL late_ack_mstall cyc=%0d got=%b exp=%b", i, mstall, (i < 4)); end
      @(posedge sclk); #1;
    end
    checks++; if (merr !== 1'b0) begin failures++; $display("FAIL late_ack_merr got=%b exp=0", merr); end
    checks++; if (mwre !== 1'b1) begin failures++; $display("FAIL late_ack_mwre got=%b exp=1", mwre); end
    checks++; if (mdat !== 32'h000000F0) begin failures++; $display("FAIL late_ack_mdat got=%h exp=%h", mdat, 32'h000000F0); end
  endtask

  task automatic test_back_to_back();
    @(negedge sclk);
    idle_inputs();
    sena = 1; xstb = 1; dwb_ack = 1; xwen = 1;
    xsel = SEL_B1; xfn3 = F3_LB; dwb_dti = 32'h00007F00; xrd = 5'd1;
    #1;
    checks++; if (mstall !== 1'b0) begin failures++; $display("FAIL b2b_mstall got=%b exp=0", mstall); end
    @(posedge sclk); #1;
    checks++; if (mdat !== 32'h0000007F) begin failures++; $display("FAIL b2b_lb_mdat got=%h exp=%h", mdat, 32'h0000007F); end
    @(negedge sclk);
    xsel = SEL_W0; xfn3 = F3_LW; dwb_dti = 32'hDEADBEEF; xrd = 5'd2;
    @(posedge sclk); #1;
    checks++; if (mdat !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_lw_mdat got=%h exp=%h", mdat, 32'hDEADBEEF); end
    checks++; if (mrd !== 5'd2) begin failures++; $display("FAIL b2b_lw_mrd got=%0d exp=2", mrd); end
    @(negedge sclk);
    xsel = SEL_H0; xfn3 = F3_LH; dwb_dti = 32'h12348001; xrd = 5'd0;
    @(posedge sclk); #1;
    checks++; if (mdat !== 32'hFFFF8001) begin failures++; $display("FAIL b2b_lh_mdat got=%h exp=%h", mdat, 32'hFFFF8001); end
    checks++; if (mwre !== 1'b1 || mrd !== 5'd0) begin failures++; $display("FAIL b2b_x0 got mwre=%b mrd=%0d exp mwre=1 mrd=0", mwre, mrd); end
  endtask

  task automatic test_illegal_and_alu();
    @(negedge sclk);
    idle_inputs();
    sena = 1; xalu = 32'hCAFE0001; xrd = 5'd4; xwen = 1;
    @(posedge sclk); #1;
    checks++; if (mdat !== 32'hCAFE0001) begin failures++; $display("FAIL alu_pre_mdat got=%h exp=%h", mdat, 32'hCAFE0001); end
    @(negedge sclk);
    xstb = 1; dwb_ack = 1; xsel = 4'b0110; xfn3 = F3_LH; dwb_dti = 32'h55667788; xrd = 5'd6;
    @(posedge sclk); #1;
    checks++; if (merr !== 1'b1) begin failures++; $display("FAIL ill_lane_merr got=%b exp=1", merr); end
    checks++; if (mwre !== 1'b0) begin failures++; $display("FAIL ill_lane_mwre got=%b exp=0", mwre); end
    checks++; if (mdat !== 32'hCAFE0001) begin failures++; $display("FAIL ill_lane_mdat got=%h exp=%h", mdat, 32'hCAFE0001); end
    @(negedge sclk);
    xsel = SEL_B0; xfn3 = F3_LH;
    @(posedge sclk); #1;
    checks++; if (merr !== 1'b1 || mwre !== 1'b0) begin failures++; $display("FAIL ill_size got merr=%b mwre=%b exp merr=1 mwre=0", merr, mwre); end
    @(negedge sclk);
    xsel = SEL_W0; xfn3 = 3'b011;
    @(posedge sclk); #1;
    checks++; if (merr !== 1'b1 || mwre !== 1'b0) begin failures++; $display("FAIL ill_fn3 got merr=%b mwre=%b exp merr=1 mwre=0", merr, mwre); end
    @(negedge sclk);
    idle_inputs();
    sena = 0; xalu = 32'h00001234; xrd = 5'd8; xwen = 1;
    @(posedge sclk); #1;
    checks++; if (mwre !== 1'b0 || merr !== 1'b0) begin failures++; $display("FAIL alu_hold got mwre=%b merr=%b exp 0 0", mwre, merr); end
    checks++; if (mdat !== 32'hCAFE0001) begin failures++; $display("FAIL alu_hold_mdat got=%h exp=%h", mdat, 32'hCAFE0001); end
    @(negedge sclk);
    sena = 1;
    @(posedge sclk); #1;
    checks++; if (mdat !== 32'h00001234) begin failures++; $display("FAIL alu_mdat got=%h exp=%h", mdat, 32'h00001234); end
    checks++; if (mwre !== 1'b1 || mrd !== 5'd8) begin failures++; $display("FAIL alu_wr got mwre=%b mrd=%0d exp 1 8", mwre, mrd); end
  endtask

  task automatic test_srst_wait();
    @(negedge sclk);
    idle_inputs();
    sena = 1; xstb = 1; xsel = SEL_W0; xfn3 = F3_LW; dwb_dti = 32'h87654321; xrd = 5'd12; xwen = 1;
    repeat (3) @(posedge sclk);
    #1;
    checks++; if (dut.r_cnt !== 8'd2) begin failures++; $display("FAIL srst_pre_cnt got=%0d exp=2", dut.r_cnt); end
    @(negedge sclk);
    srst = 1; dwb_ack = 1;
    @(posedge sclk); #1;
    @(negedge sclk);
    @(posedge sclk); #1;
    checks++; if (merr !== 1'b0 || mwre !== 1'b0) begin failures++; $display("FAIL srst_out got merr=%b mwre=%b exp 0 0", merr, mwre); end
    checks++; if (mdat !== 32'h0 || mrd !== 5'd0) begin failures++; $display("FAIL srst_data got mdat=%h mrd=%0d exp 0 0", mdat, mrd); end
    @(negedge sclk);
    idle_inputs();
    @(posedge sclk); #1;
    checks++; if (dut.r_state !== IDLE) begin failures++; $display("FAIL srst_state got=%0d exp=%0d", dut.r_state, IDLE); end
    checks++; if (merr !== 1'b0 || mwre !== 1'b0 || mdat !== 32'h0) begin failures++; $display("FAIL srst_after got merr=%b mwre=%b mdat=%h exp 0 0 0", merr, mwre, mdat); end
    #1;
    checks++; if (mstall !== 1'b0) begin failures++; $display("FAIL srst_mstall got=%b exp=0", mstall); end
  endtask

  initial begin
    idle_inputs();
    srst = 1'b1;
    test_reset();
    test_lb();
    test_lhu();
    test_store();
    test_timeout();
    test_ack_at_timeout();
    test_back_to_back();
    test_illegal_and_alu();
    test_srst_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/t5_load.md
Name: t5_load

Overview:
- Memory-return / writeback stage of the t5 integer pipeline, directly downstream of the data-bus request stage.
- Consumes that stage's registered bus controls (xstb, xwre, xsel) together with the Wishbone read data and ack.
- Holds the pipeline until the access completes or times out, then extracts and sign- or zero-extends load data per funct3.
- Registers the register-file write port (data, index, enable); ALU results of non-memory instructions pass through the same register.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
TMO, 255, maximum cycles in an access before abort; legal range 2..255.

Ports:
sclk  in  1  clock, rising edge.
srst  in  1  synchronous reset, active-high.
sena  in  1  pipeline enable from hazard control; excludes mstall.
dwb_dti  in  XLEN  Wishbone read data.
dwb_ack  in  1  Wishbone acknowledge.
xstb  in  1  data access in progress (from request stage).
xwre  in  1  access is a store.
xsel  in  4  byte-lane select of the current access.
xfn3  in  3  funct3 [14:12] of the instruction in this stage.
xrd  in  5  destination register index.
xwen  in  1  instruction writes rd.
xalu  in  XLEN  ALU result for non-memory instructions.
mstall  out  1  combinational pipeline hold request.
mdat  out  XLEN  register-file write data.
mrd  out  5  register-file write index.
mwre  out  1  register-file write enable.
merr  out  1  one-cycle pulse: bus timeout or illegal load lane.

Behaviour:
- Reset: srst is synchronous and active-high on sclk. It forces state IDLE, cnt=0, mdat=0, mrd=0, mwre=0, merr=0. dwb_ack is ignored while srst=1. srst in WAIT abandons the access silently, with no merr.
- FSM state IDLE:
  - xstb=1 and dwb_ack=0: go to WAIT, mstall=1.
  - xstb=1 and dwb_ack=1: access completes this cycle, mstall=0.
- FSM state WAIT:
  - cnt (8-bit) increments each cycle.
  - dwb_ack=1: complete, mstall=0, go to IDLE, cnt=0.
  - No ack and cnt==TMO-1: abort, mstall=0, go to IDLE, cnt=0.
  - Otherwise mstall=1.
  - Ack and timeout in the same cycle: ack wins.
- mstall is never asserted while xstb=0. Stall length equals the ack wait. Maximum stall is TMO cycles, followed by the abort cycle.
- Advance condition: adv = sena & !mstall. Output registers load only when adv=1. When adv=0, mwre<=0 and merr<=0 (bubble); mdat and mrd hold.
- On adv with xstb=0 (non-memory instruction): mdat<=xalu, mrd<=xrd, mwre<=xwen.
- On adv with xstb=1 and xwre=1 (store): mwre<=0, mrd<=xrd.
- On adv with xstb=1 and xwre=0, completed by ack (load):
  - Lane extract from dwb_dti by xsel: 0001 [7:0]; 0010 [15:8]; 0100 [23:16]; 1000 [31:24]; 0011 [15:0]; 1100 [31:16]; 1111 [31:0].
  - Extension by xfn3: 000 LB sign-8; 001 LH sign-16; 010 LW; 100 LBU zero-8; 101 LHU zero-16.
  - Result: mdat<=extended value, mrd<=xrd, mwre<=xwen.
- Illegal load: any other xsel, an xfn3/xsel size mismatch, or xfn3 011/110/111. Result: mwre<=0, merr<=1, mdat holds.
- Timeout abort (load or store): merr<=1, mwre<=0.
- Latency: mdat/mwre are valid on the first sclk edge after the completing cycle (1 cycle).
- rd=x0 is passed through; the register file discards writes to x0.

Decomposition:
- Shared package t5_pkg holds:
  - funct3 load constants LB/LH/LW/LBU/LHU;
  - xsel lane constants (B0..B3, H0, H2, W0), shared with the request stage;
  - FSM state encodings IDLE/WAIT.
- One combinational sub-module, t5_load_align: inputs dwb_dti, xsel, xfn3; outputs extended data and an illegal flag. The FSM, counter and output registers stay in t5_load.

Test Plan:
- LB, xsel=0100, dti=0x12803456, ack in the first cycle, xrd=5 -> mstall stays 0; next cycle mdat=0xFFFFFF80, mrd=5, mwre=1.
- LHU, xsel=1100, dti=0xBEEF0000, ack on the 4th xstb cycle -> mstall=1 for exactly 3 cycles; then mdat=0x0000BEEF, mwre=1.
- SW, xsel=1111, xwre=1, ack after 1 wait -> mstall 1 cycle, mwre=0, merr=0.
- TMO=4, load never acked -> mstall=1 for 4 cycles, then 0; next cycle merr=1 for exactly 1 cycle, mwre=0; FSM back in IDLE.
- LH with xsel=0110 -> merr=1, mwre=0, mdat unchanged. ALU op (xstb=0, xalu=0x1234, xwen=1) with sena=0 -> mwre=0; after sena=1 -> mdat=0x1234, mwre=1.
- srst during WAIT (cnt=2), ack arriving with srst still high -> after reset, state IDLE, all outputs 0, no merr, no write.
